// File: rtl/add_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// add_arbiter: round-robin arbiter sharing one W-bit adder among N_REQ requesters.
// Rev 1.0 -- initial release.
module add_arbiter #(
  parameter int N_REQ = 4,
  parameter int W     = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req_valid,
  output logic [N_REQ-1:0]         req_ready,
  input  logic [N_REQ*W-1:0]       req_a,
  input  logic [N_REQ*W-1:0]       req_b,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [W:0]               rsp_y,
  output logic [$clog2(N_REQ)-1:0] rsp_id,
  output logic                     busy,
  output logic [7:0]               txn_count
);

  localparam int IW = $clog2(N_REQ);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t        state;
  logic [IW-1:0] ptr;
  logic [IW-1:0] win;
  logic [IW-1:0] cand;
  logic          found;
  logic [W-1:0]  sel_a;
  logic [W-1:0]  sel_b;
  logic [W-1:0]  op_a;
  logic [W-1:0]  op_b;

  // Search starts one past the last winner and wraps, so the last winner has lowest priority.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = IW'((int'(ptr) + k) % N_REQ);
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    sel_a     = '0;
    sel_b     = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win == IW'(i)) begin
        sel_a = req_a[i*W +: W];
        sel_b = req_b[i*W +: W];
      end
      req_ready[i] = (state == IDLE) && found && (win == IW'(i));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= IW'(N_REQ - 1);
      op_a      <= '0;
      op_b      <= '0;
      rsp_valid <= 1'b0;
      rsp_y     <= '0;
      rsp_id    <= '0;
      busy      <= 1'b0;
      txn_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            op_a   <= sel_a;
            op_b   <= sel_b;
            rsp_id <= win;
            ptr    <= win;
            busy   <= 1'b1;
            state  <= CALC;
          end
        end
        CALC: begin
          rsp_y     <= {1'b0, op_a} + {1'b0, op_b};
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            if (txn_count != 8'hFF) begin
              txn_count <= txn_count + 8'd1;
            end
            state <= IDLE;
          end
        end
        default: begin
          rsp_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_add_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// tb_add_arbiter: scoreboard bench for add_arbiter with a transaction-level reference model.
// Rev 1.0 -- initial release.
module tb_add_arbiter;

  localparam int N = 4;
  localparam int W = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [W:0]     rsp_y;
  logic [1:0]     rsp_id;
  logic           busy;
  logic [7:0]     txn_count;

  add_arbiter #(.N_REQ(N), .W(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_y(rsp_y), .rsp_id(rsp_id),
    .busy(busy), .txn_count(txn_count)
  );

  always #5 clk = ~clk;

  typedef struct { int id; int y; } exp_t;
  exp_t q[$];

  int checks = 0;
  int errors = 0;

  // Reference model state
  int       mptr;
  bit       in_flight;
  int       age;
  int       mcount;
  logic [N-1:0] granted_vec;

  // Requester drivers
  logic [N-1:0] dv;
  logic [N-1:0] refill;
  int       da [N];
  int       db [N];
  bit       rand_en;
  int       rsp_mode;   // 0 low, 1 high, 2 random

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, got, exp, $time);
    end
  endtask

  function automatic int rr_pick(input logic [N-1:0] v, input int p);
    for (int k = 1; k <= N; k++) begin
      if (v[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  task automatic model_reset();
    q.delete();
    mptr        = N - 1;
    in_flight   = 1'b0;
    age         = 0;
    mcount      = 0;
    granted_vec = '0;
    dv          = '0;
    refill      = '0;
  endtask

  task automatic apply();
    req_valid = dv;
    for (int i = 0; i < N; i++) begin
      req_a[i*W +: W] = W'(da[i]);
      req_b[i*W +: W] = W'(db[i]);
    end
    case (rsp_mode)
      0:       rsp_ready = 1'b0;
      1:       rsp_ready = 1'b1;
      default: rsp_ready = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (granted_vec[i] && !refill[i]) dv[i] = 1'b0;
    end
    granted_vec = '0;
    if (rand_en) begin
      for (int i = 0; i < N; i++) begin
        if (!dv[i] && $urandom_range(0, 2) == 0) begin
          dv[i] = 1'b1;
          da[i] = int'($urandom_range(0, (1 << W) - 1));
          db[i] = int'($urandom_range(0, (1 << W) - 1));
        end
      end
    end
    apply();
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, int'(req_ready), 0);
    chk({tag, "_rsp_valid"}, int'(rsp_valid), 0);
    chk({tag, "_rsp_y"},     int'(rsp_y), 0);
    chk({tag, "_rsp_id"},    int'(rsp_id), 0);
    chk({tag, "_busy"},      int'(busy), 0);
    chk({tag, "_txn_count"}, int'(txn_count), 0);
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_reset_outputs(tag);
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic wait_idle(input string tag);
    bit done = 1'b0;
    for (int k = 0; k < 200 && !done; k++) begin
      if (!in_flight && dv == '0) done = 1'b1;
      else step();
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL %s_drain: got busy/pending, expected idle within 200 cycles", tag);
    end
  endtask

  // Monitor: model decides what the DUT should show this cycle, then advances across the next edge.
  always @(negedge clk) begin
    if (rst_n) begin
      logic [N-1:0] exp_g;
      bit           exp_rv;
      int           w;
      if (in_flight) age++;
      exp_rv = in_flight && (age >= 2);
      chk("busy", int'(busy), int'(in_flight));
      chk("rsp_valid", int'(rsp_valid), int'(exp_rv));
      chk("txn_count", int'(txn_count), mcount);
      exp_g = '0;
      w     = -1;
      if (!in_flight && req_valid != '0) begin
        w = rr_pick(req_valid, mptr);
        exp_g[w] = 1'b1;
      end
      chk("req_ready", int'(req_ready), int'(exp_g));
      if (rsp_valid) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rsp_unexpected: got rsp_y=%0d rsp_id=%0d, expected no response", rsp_y, rsp_id);
        end else begin
          chk("rsp_y", int'(rsp_y), q[0].y);
          chk("rsp_id", int'(rsp_id), q[0].id);
        end
      end
      if (exp_rv && rsp_ready) begin
        if (q.size() > 0) void'(q.pop_front());
        if (mcount < 255) mcount++;
        in_flight = 1'b0;
      end
      if (w >= 0) begin
        q.push_back('{id: w, y: da[w] + db[w]});
        mptr        = w;
        in_flight   = 1'b1;
        age         = 0;
        granted_vec = exp_g;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no completion, expected $finish before 200 us");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n     = 1'b0;
    rand_en   = 1'b0;
    rsp_mode  = 1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      da[i] = 0;
      db[i] = 0;
    end
    model_reset();
    #3;
    check_reset_outputs("por");
    step();
    step();
    rst_n = 1'b1;

    // Single request: 1 + 3 from requester 0.
    dv[0] = 1'b1; da[0] = 1; db[0] = 3;
    run(6);
    chk("single_txn_count", int'(txn_count), 1);

    // Contention, fresh pointer: expect 0,1,2,3,0 with sums 11,15,30,0,11.
    do_reset("rst_a");
    da[0] = 5;  db[0] = 6;
    da[1] = 7;  db[1] = 8;
    da[2] = 15; db[2] = 15;
    da[3] = 0;  db[3] = 0;
    dv = '1; refill = '1;
    run(15);
    refill = '0;
    wait_idle("contention");

    // Wrap: ptr = 3 with 1001 -> grant 0, then 3.
    do_reset("rst_b");
    da[0] = 2; db[0] = 1;
    da[3] = 4; db[3] = 9;
    dv = 4'b1001; refill = 4'b1001;
    run(7);
    refill = '0;
    wait_idle("wrap");

    // Back-pressure on a 9 + 9 result while another requester waits.
    rsp_mode = 0;
    da[2] = 9; db[2] = 9; dv[2] = 1'b1;
    step();
    da[1] = 3; db[1] = 3; dv[1] = 1'b1;
    run(7);
    chk("bp_rsp_valid_held", int'(rsp_valid), 1);
    chk("bp_rsp_y_held", int'(rsp_y), 18);
    rsp_mode = 1;
    wait_idle("backpressure");

    // Reset during CALC discards the in-flight transaction.
    da[1] = 6; db[1] = 7; dv = 4'b0010;
    step();
    step();
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_calc");
    model_reset();
    step();
    step();
    rst_n = 1'b1;
    run(4);
    for (int i = 0; i < N; i++) begin
      da[i] = i + 1;
      db[i] = 2 * i;
    end
    dv = '1;
    wait_idle("post_reset");

    // Randomized traffic with random back-pressure.
    rand_en  = 1'b1;
    rsp_mode = 2;
    run(300);
    rand_en  = 1'b0;
    rsp_mode = 1;
    wait_idle("random");

    // Saturation: well over 255 back-to-back transactions.
    da[0] = 15; db[0] = 15; dv[0] = 1'b1; refill[0] = 1'b1;
    run(800);
    refill = '0;
    wait_idle("saturation");
    run(3);
    chk("txn_count_saturated", int'(txn_count), 255);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
